layer_compositor: RTL and testbench
===================================

LAYER_COMPOSITOR -- requirements
Module: layer_compositor

Interface
REQ-001 SHALL take parameter NUM_LAYERS, default 4 (legal 2..8): number of priority-ordered sprite layers.
REQ-002 SHALL take parameter CH_BITS, default 2 (legal 1..4): bits per colour channel; C = 3*CH_BITS, packed {R,G,B}.
REQ-003 SHALL take parameter PIPE_DEPTH, default 2 (legal 1..4): pixel-path latency in cycles.
REQ-004 SHALL have the following ports; one clock, reset asynchronous and active-high.
  clk  input  1  pixel clock
  rst  input  1  asynchronous active-high reset
  blank  input  1  beam outside visible area
  hsync_in  input  1  beam hsync, active-low
  vsync_in  input  1  beam vsync, active-low
  layer_hit  input  NUM_LAYERS  per-layer coverage of current pixel
  layer_color  input  NUM_LAYERS*C  layer i colour at bits [i*C +: C]
  layer_en  input  NUM_LAYERS  per-layer enable
  bg_color  input  C  background colour
  rgb_out  output  C  composited colour, registered
  hsync_out  output  1  hsync delayed to match rgb_out
  vsync_out  output  1  vsync delayed to match rgb_out
  collision_pairs  output  P  per-pair collision flags, P = NUM_LAYERS*(NUM_LAYERS-1)/2
  collision_valid  output  1  collision report pending
  collision_ack  input  1  consumer acknowledges report
  collision_overrun  output  1  report was merged before ack

Function
REQ-005 SHALL select the lowest-index layer i with layer_hit[i] && layer_en[i]; otherwise bg_color; C'0 when blank.
REQ-006 SHALL present that selection on rgb_out exactly PIPE_DEPTH cycles after its inputs are sampled.
REQ-007 SHALL delay hsync_in/vsync_in by exactly PIPE_DEPTH cycles, so syncs stay aligned with rgb_out.
REQ-008 SHALL number pairs (i,j), i<j, i-major: for 4 layers (0,1)=0, (0,2)=1, (0,3)=2, (1,2)=3, (1,3)=4, (2,3)=5.
REQ-009 SHALL set sticky accumulator bit (i,j) on any non-blank cycle where layers i and j are both hit and both enabled.
REQ-010 SHALL define a frame boundary as the cycle where vsync_in is 0 and was 1 the previous cycle.
REQ-011 On a boundary with collision_valid=0 or collision_ack=1: collision_pairs <= accumulator, collision_valid <= 1, collision_overrun <= 0.
REQ-012 On a boundary with collision_valid=1 and collision_ack=0: collision_pairs <= collision_pairs | accumulator, collision_overrun <= 1.
REQ-013 SHALL clear the accumulator on every boundary; hits sampled in the boundary cycle itself count toward the new frame.
REQ-014 SHALL clear collision_valid and collision_overrun on collision_ack without a boundary; ack with valid=0 has no effect.
REQ-015 collision_pairs SHALL hold its value until the next boundary; ack does not clear it.

Reset
REQ-016 rst SHALL asynchronously force rgb_out=0, hsync_out=1, vsync_out=1, all delay stages idle (syncs 1, colour 0).
REQ-017 rst SHALL clear the accumulator, collision_pairs, collision_valid, collision_overrun and the previous-vsync register (reset value 1).
REQ-018 Reset mid-frame SHALL discard partial accumulation; the first report after release covers only post-reset cycles.

Configuration
REQ-019 Macro COMPOSITOR_COLLISION_EN defined: REQ-008..REQ-015 are implemented.
REQ-020 Macro undefined: no accumulator or report registers; collision_pairs, collision_valid, collision_overrun tied 0; collision_ack ignored; pixel path unchanged.

Structure
REQ-021 compositor_pkg SHALL hold default NUM_LAYERS, CH_BITS and PIPE_DEPTH, the pair-count function, and the pair-index function (i,j) -> index.
REQ-022 Sync and colour alignment SHALL use one sub-module, sync_delay (parametrised width and depth shift register with async reset value).

Verification
REQ-023 Layers 0 and 2 both hit, all enabled, colours 6'h30/6'h0C -> rgb_out=6'h30 exactly 2 cycles later (defaults).
REQ-024 layer_en=4'b1110, same stimulus -> rgb_out=6'h0C; with blank=1 -> rgb_out=0; hsync_out is hsync_in delayed 2 cycles.
REQ-025 Layers 1 and 3 overlap 5 pixels in frame N, vsync edge -> collision_pairs=6'b010000, collision_valid=1, collision_overrun=0.
REQ-026 No ack; frame N+1 has 0/1 overlap -> collision_pairs=6'b010001, collision_overrun=1; ack -> valid=0, overrun=0, pairs held.
REQ-027 Ack asserted in the boundary cycle -> valid stays 1, pairs = new frame only, overrun=0.
REQ-028 Assert rst mid-frame after overlaps -> all outputs reach reset values immediately; next boundary reports only post-reset overlaps.

Source files
------------

// File: rtl/compositor_pkg.sv
// Shared defaults and pair-numbering helpers for the layer compositor.
// The pair numbering (i,j), i<j, is i-major: for four layers the order is
// (0,1) (0,2) (0,3) (1,2) (1,3) (2,3).
package compositor_pkg;

    localparam int DEF_NUM_LAYERS = 4;
    localparam int DEF_CH_BITS    = 2;
    localparam int DEF_PIPE_DEPTH = 2;

    // Number of unordered layer pairs.
    function automatic int pair_count(input int n);
        return (n * (n - 1)) / 2;
    endfunction

    // Flat index of pair (i,j) with i<j among n layers.
    function automatic int pair_index(input int i, input int j, input int n);
        return i * n - (i * (i + 1)) / 2 + (j - i - 1);
    endfunction

endpackage

// File: rtl/sync_delay.sv
// Fixed-depth shift register with a configurable asynchronous reset value.
// Used to carry the composited colour together with the beam syncs so that
// all of them leave the block on the same cycle.
module sync_delay #(
    parameter int               WIDTH   = 1,
    parameter int               DEPTH   = 1,
    parameter logic [WIDTH-1:0] RST_VAL = '0
) (
    input  logic             clk,
    input  logic             rst,
    input  logic [WIDTH-1:0] d_i,
    output logic [WIDTH-1:0] q_o
);

    logic [WIDTH-1:0] stage_q [DEPTH];

    // Shift one stage per clock; reset puts every stage in its idle value.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            for (int k = 0; k < DEPTH; k++) begin
                stage_q[k] <= RST_VAL;
            end
        end else begin
            stage_q[0] <= d_i;
            for (int k = 1; k < DEPTH; k++) begin
                stage_q[k] <= stage_q[k-1];
            end
        end
    end

    assign q_o = stage_q[DEPTH-1];

endmodule

// File: rtl/layer_compositor.sv
// Priority sprite-layer compositor with sync-aligned output and optional
// per-frame collision reporting.
// Optional feature macro: COMPOSITOR_COLLISION_EN (collision accumulator and
// report handshake). When undefined, the collision outputs are tied to zero.
module layer_compositor
    import compositor_pkg::*;
#(
    parameter int NUM_LAYERS = DEF_NUM_LAYERS,
    parameter int CH_BITS    = DEF_CH_BITS,
    parameter int PIPE_DEPTH = DEF_PIPE_DEPTH
) (
    input  logic                                 clk,
    input  logic                                 rst,
    input  logic                                 blank,
    input  logic                                 hsync_in,
    input  logic                                 vsync_in,
    input  logic [NUM_LAYERS-1:0]                layer_hit,
    input  logic [NUM_LAYERS*3*CH_BITS-1:0]      layer_color,
    input  logic [NUM_LAYERS-1:0]                layer_en,
    input  logic [3*CH_BITS-1:0]                 bg_color,
    output logic [3*CH_BITS-1:0]                 rgb_out,
    output logic                                 hsync_out,
    output logic                                 vsync_out,
    output logic [pair_count(NUM_LAYERS)-1:0]    collision_pairs,
    output logic                                 collision_valid,
    input  logic                                 collision_ack,
    output logic                                 collision_overrun
);

    localparam int C = 3 * CH_BITS;
    localparam int P = pair_count(NUM_LAYERS);

    logic [C-1:0]   pix_sel;
    logic [C+1:0]   dly_out;

    // Lowest-index enabled hit wins; scanning downward lets it overwrite last.
    always_comb begin
        pix_sel = bg_color;
        for (int i = NUM_LAYERS - 1; i >= 0; i--) begin
            if (layer_hit[i] && layer_en[i]) begin
                pix_sel = layer_color[i*C +: C];
            end
        end
        if (blank) begin
            pix_sel = '0;
        end
    end

    // Colour and syncs share one delay line so they can never drift apart;
    // the final stage is the output register.
    sync_delay #(
        .WIDTH   (C + 2),
        .DEPTH   (PIPE_DEPTH),
        .RST_VAL ({2'b11, {C{1'b0}}})
    ) u_align (
        .clk (clk),
        .rst (rst),
        .d_i ({hsync_in, vsync_in, pix_sel}),
        .q_o (dly_out)
    );

    assign {hsync_out, vsync_out, rgb_out} = dly_out;

`ifdef COMPOSITOR_COLLISION_EN

    logic [P-1:0] pair_hit;
    logic [P-1:0] acc_q, acc_d;
    logic [P-1:0] pairs_q, pairs_d;
    logic         valid_q, valid_d;
    logic         ovr_q, ovr_d;
    logic         vs_prev_q;
    logic         boundary;

    // Falling edge of vsync marks the start of a new frame.
    assign boundary = vs_prev_q && !vsync_in;

    // Flag every pair of layers that are both visible on this pixel.
    always_comb begin
        pair_hit = '0;
        for (int i = 0; i < NUM_LAYERS; i++) begin
            for (int j = i + 1; j < NUM_LAYERS; j++) begin
                if (!blank && layer_hit[i] && layer_en[i]
                           && layer_hit[j] && layer_en[j]) begin
                    pair_hit[pair_index(i, j, NUM_LAYERS)] = 1'b1;
                end
            end
        end
    end

    // Accumulate per frame and publish on the boundary; an unacknowledged
    // report is merged rather than lost, and that merge is flagged.
    always_comb begin
        acc_d   = boundary ? pair_hit : (acc_q | pair_hit);
        pairs_d = pairs_q;
        valid_d = valid_q;
        ovr_d   = ovr_q;
        if (boundary) begin
            if (!valid_q || collision_ack) begin
                pairs_d = acc_q;
                valid_d = 1'b1;
                ovr_d   = 1'b0;
            end else begin
                pairs_d = pairs_q | acc_q;
                ovr_d   = 1'b1;
            end
        end else if (collision_ack && valid_q) begin
            valid_d = 1'b0;
            ovr_d   = 1'b0;
        end
    end

    // Collision state registers; previous vsync idles high so reset itself
    // never looks like a frame boundary.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            acc_q     <= '0;
            pairs_q   <= '0;
            valid_q   <= 1'b0;
            ovr_q     <= 1'b0;
            vs_prev_q <= 1'b1;
        end else begin
            acc_q     <= acc_d;
            pairs_q   <= pairs_d;
            valid_q   <= valid_d;
            ovr_q     <= ovr_d;
            vs_prev_q <= vsync_in;
        end
    end

    assign collision_pairs   = pairs_q;
    assign collision_valid   = valid_q;
    assign collision_overrun = ovr_q;

`else

    logic unused_ack;

    assign unused_ack        = collision_ack;
    assign collision_pairs   = '0;
    assign collision_valid   = 1'b0;
    assign collision_overrun = 1'b0;

`endif

endmodule

// File: tb/tb_layer_compositor.sv
// Scoreboard bench for layer_compositor at default parameters.
// Stimulus pushes hand-computed expectations into queues tagged with the
// cycle they are due; a monitor on the falling clock edge pops and compares.
module tb_layer_compositor;

    localparam int NL = 4;
    localparam int CB = 2;
    localparam int PD = 2;
    localparam int C  = 3 * CB;
    localparam int P  = 6;

    logic            clk = 1'b0;
    logic            rst = 1'b0;
    logic            blank = 1'b0;
    logic            hsync_in = 1'b1;
    logic            vsync_in = 1'b1;
    logic [NL-1:0]   layer_hit = '0;
    logic [NL*C-1:0] layer_color;
    logic [NL-1:0]   layer_en = '1;
    logic [C-1:0]    bg_color = 6'h15;
    logic [C-1:0]    rgb_out;
    logic            hsync_out;
    logic            vsync_out;
    logic [P-1:0]    collision_pairs;
    logic            collision_valid;
    logic            collision_ack = 1'b0;
    logic            collision_overrun;

    int cyc = 0;
    int n_chk = 0;
    int n_fail = 0;

    typedef struct {
        int          due;
        logic [5:0]  rgb;
        logic        hs;
        logic        vs;
    } pix_t;

    typedef struct {
        int          due;
        logic [5:0]  pairs;
        logic        v;
        logic        o;
    } col_t;

    pix_t pq[$];
    col_t cq[$];

    layer_compositor #(
        .NUM_LAYERS (NL),
        .CH_BITS    (CB),
        .PIPE_DEPTH (PD)
    ) dut (
        .clk               (clk),
        .rst               (rst),
        .blank             (blank),
        .hsync_in          (hsync_in),
        .vsync_in          (vsync_in),
        .layer_hit         (layer_hit),
        .layer_color       (layer_color),
        .layer_en          (layer_en),
        .bg_color          (bg_color),
        .rgb_out           (rgb_out),
        .hsync_out         (hsync_out),
        .vsync_out         (vsync_out),
        .collision_pairs   (collision_pairs),
        .collision_valid   (collision_valid),
        .collision_ack     (collision_ack),
        .collision_overrun (collision_overrun)
    );

    always #5 clk = ~clk;

    always @(posedge clk) cyc <= cyc + 1;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_chk++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: actual %0h required %0h (cycle %0d)", name, act, exp, cyc);
        end
    endtask

    // Drive one pixel for one clock and queue its expected delayed output.
    task automatic step(input logic [3:0] hit, input logic [3:0] en, input logic bl,
                        input logic hs, input logic vs, input logic ack,
                        input logic [5:0] exp_rgb);
        pix_t e;
        layer_hit     = hit;
        layer_en      = en;
        blank         = bl;
        hsync_in      = hs;
        vsync_in      = vs;
        collision_ack = ack;
        e.due = cyc + PD;
        e.rgb = exp_rgb;
        e.hs  = hs;
        e.vs  = vs;
        pq.push_back(e);
        @(posedge clk);
        #1;
    endtask

    // Expected collision outputs one clock after the inputs currently driven.
    task automatic push_coll(input logic [5:0] p, input logic v, input logic o);
        col_t e;
        e.due = cyc + 1;
`ifdef COMPOSITOR_COLLISION_EN
        e.pairs = p;
        e.v     = v;
        e.o     = o;
`else
        e.pairs = (p & 6'h00);
        e.v     = 1'b0 & v;
        e.o     = 1'b0 & o;
`endif
        cq.push_back(e);
    endtask

    task automatic check_reset_outputs(input string tag);
        chk({tag, "_rgb"},   32'(rgb_out), 32'h0);
        chk({tag, "_hs"},    32'(hsync_out), 32'h1);
        chk({tag, "_vs"},    32'(vsync_out), 32'h1);
        chk({tag, "_pairs"}, 32'(collision_pairs), 32'h0);
        chk({tag, "_valid"}, 32'(collision_valid), 32'h0);
        chk({tag, "_ovr"},   32'(collision_overrun), 32'h0);
    endtask

    // Monitor: compare every expectation that has come due.
    initial begin
        pix_t p;
        col_t c;
        forever begin
            @(negedge clk);
            while (pq.size() > 0 && pq[0].due <= cyc) begin
                p = pq.pop_front();
                chk("pix_due", 32'(cyc), 32'(p.due));
                chk("rgb_out", 32'(rgb_out), 32'(p.rgb));
                chk("hsync_out", 32'(hsync_out), 32'(p.hs));
                chk("vsync_out", 32'(vsync_out), 32'(p.vs));
            end
            while (cq.size() > 0 && cq[0].due <= cyc) begin
                c = cq.pop_front();
                chk("col_due", 32'(cyc), 32'(c.due));
                chk("collision_pairs", 32'(collision_pairs), 32'(c.pairs));
                chk("collision_valid", 32'(collision_valid), 32'(c.v));
                chk("collision_overrun", 32'(collision_overrun), 32'(c.o));
            end
        end
    end

    initial begin
        #200000;
        $display("FAIL watchdog: actual timeout required finish");
        $fatal(1, "watchdog expired");
    end

    initial begin
        // Colours: L0=30, L1=03, L2=0C, L3=3F; background 15.
        layer_color = {6'h3F, 6'h0C, 6'h03, 6'h30};

        #1 rst = 1'b1;
        #2 check_reset_outputs("reset");
        @(posedge clk);
        @(posedge clk);
        #1 rst = 1'b0;

        // Pixel priority / enable / blank vectors; hsync toggles each cycle.
        step(4'b0101, 4'b1111, 1'b0, 1'b0, 1'b1, 1'b0, 6'h30);
        step(4'b0101, 4'b1110, 1'b0, 1'b1, 1'b1, 1'b0, 6'h0C);
        step(4'b0101, 4'b1111, 1'b1, 1'b0, 1'b1, 1'b0, 6'h00);
        step(4'b0000, 4'b1111, 1'b0, 1'b1, 1'b1, 1'b0, 6'h15);
        step(4'b1000, 4'b1111, 1'b0, 1'b0, 1'b1, 1'b0, 6'h3F);
        step(4'b1010, 4'b1101, 1'b0, 1'b1, 1'b1, 1'b0, 6'h3F);
        step(4'b1111, 4'b0000, 1'b0, 1'b0, 1'b1, 1'b0, 6'h15);
        step(4'b0010, 4'b1111, 1'b0, 1'b1, 1'b1, 1'b0, 6'h03);

        // Only the first vector overlapped enabled layers (0,2) -> pair 1.
        push_coll(6'b000010, 1'b1, 1'b0);
        step(4'b0000, 4'b1111, 1'b0, 1'b1, 1'b0, 1'b0, 6'h15);
        push_coll(6'b000010, 1'b0, 1'b0);
        step(4'b0000, 4'b1111, 1'b0, 1'b1, 1'b1, 1'b1, 6'h15);

        // Frame N: layers 1 and 3 overlap for 5 pixels.
        for (int i = 0; i < 5; i++) begin
            step(4'b1010, 4'b1111, 1'b0, i[0], 1'b1, 1'b0, 6'h03);
        end
        step(4'b0000, 4'b1111, 1'b0, 1'b1, 1'b1, 1'b0, 6'h15);
        push_coll(6'b010000, 1'b1, 1'b0);
        step(4'b0000, 4'b1111, 1'b0, 1'b1, 1'b0, 1'b0, 6'h15);
        push_coll(6'b010000, 1'b1, 1'b0);
        step(4'b0000, 4'b1111, 1'b0, 1'b1, 1'b0, 1'b0, 6'h15);
        step(4'b0000, 4'b1111, 1'b0, 1'b1, 1'b1, 1'b0, 6'h15);

        // Frame N+1: 0/1 overlap, no ack -> merged report with overrun.
        step(4'b0011, 4'b1111, 1'b0, 1'b0, 1'b1, 1'b0, 6'h30);
        step(4'b0000, 4'b1111, 1'b0, 1'b1, 1'b1, 1'b0, 6'h15);
        push_coll(6'b010001, 1'b1, 1'b1);
        step(4'b0000, 4'b1111, 1'b0, 1'b1, 1'b0, 1'b0, 6'h15);
        push_coll(6'b010001, 1'b0, 1'b0);
        step(4'b0000, 4'b1111, 1'b0, 1'b1, 1'b0, 1'b1, 6'h15);
        step(4'b0000, 4'b1111, 1'b0, 1'b1, 1'b1, 1'b0, 6'h15);

        // Frame N+2: 2/3 overlap; a blanked 0/1 overlap must not count.
        step(4'b1100, 4'b1111, 1'b0, 1'b0, 1'b1, 1'b0, 6'h0C);
        step(4'b0011, 4'b1111, 1'b1, 1'b1, 1'b1, 1'b0, 6'h00);
        push_coll(6'b100000, 1'b1, 1'b0);
        step(4'b0000, 4'b1111, 1'b0, 1'b1, 1'b0, 1'b0, 6'h15);
        step(4'b0000, 4'b1111, 1'b0, 1'b1, 1'b1, 1'b0, 6'h15);

        // Frame N+3: 1/2 overlap; 0/3 with layer 3 disabled does not count.
        // Ack lands in the boundary cycle -> fresh report, no overrun.
        step(4'b0110, 4'b1111, 1'b0, 1'b0, 1'b1, 1'b0, 6'h03);
        step(4'b1001, 4'b0111, 1'b0, 1'b1, 1'b1, 1'b0, 6'h30);
        push_coll(6'b001000, 1'b1, 1'b0);
        step(4'b0000, 4'b1111, 1'b0, 1'b1, 1'b0, 1'b1, 6'h15);
        step(4'b0000, 4'b1111, 1'b0, 1'b1, 1'b1, 1'b0, 6'h15);

        // Mid-frame reset after 1/3 overlaps: outputs must drop at once.
        step(4'b1010, 4'b1111, 1'b0, 1'b0, 1'b1, 1'b0, 6'h03);
        step(4'b1010, 4'b1111, 1'b0, 1'b1, 1'b1, 1'b0, 6'h03);
        rst = 1'b1;
        #2 check_reset_outputs("midrst");
        pq.delete();
        cq.delete();
        layer_hit = '0;
        #1 rst = 1'b0;
        @(posedge clk);
        #1;

        // Only the post-reset 0/3 overlap may be reported.
        step(4'b1001, 4'b1111, 1'b0, 1'b0, 1'b1, 1'b0, 6'h30);
        step(4'b0000, 4'b1111, 1'b0, 1'b1, 1'b1, 1'b0, 6'h15);
        push_coll(6'b000100, 1'b1, 1'b0);
        step(4'b0000, 4'b1111, 1'b0, 1'b1, 1'b0, 1'b0, 6'h15);
        step(4'b0000, 4'b1111, 1'b0, 1'b1, 1'b1, 1'b0, 6'h15);

        repeat (PD + 2) @(posedge clk);
        #1;
        chk("pix_queue_drained", 32'(pq.size()), 32'h0);
        chk("col_queue_drained", 32'(cq.size()), 32'h0);

        $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
        $finish;
    end

endmodule
